env_shaper: RTL and testbench

ADSR envelope shaper between the wavetable RAM read mux and the PWM generator. It takes 16-bit offset-binary wavetable samples and scales them by an 8-bit envelope. The envelope is driven by a gate (note on/off from the panel) and runs attack, decay, sustain and release phases. It emits a 10-bit offset-binary sample ready for the PWM `d_in`.

---
 rtl/env_pkg.sv | 21 ++
 rtl/env_tick_gen.sv | 29 ++
 rtl/env_shaper.sv | 198 +++++++++++++++++++
 tb/tb_env_shaper.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/env_pkg.sv
// env_pkg: shared ADSR phase encoding and constants for the envelope shaper.
package env_pkg;

  // Phase encoding; these values appear directly on the env_state output.
  typedef enum logic [2:0] {
    ENV_IDLE    = 3'd0,
    ENV_ATTACK  = 3'd1,
    ENV_DECAY   = 3'd2,
    ENV_SUSTAIN = 3'd3,
    ENV_RELEASE = 3'd4
  } env_state_t;

  localparam logic [7:0]  ENV_MAX    = 8'd255;
  localparam logic [15:0] MIDPOINT16 = 16'h8000;

  // A zero step would freeze a phase forever, so it is promoted to 1.
  function automatic logic [7:0] eff_step(input logic [7:0] step);
    return (step == 8'd0) ? 8'd1 : step;
  endfunction

endpackage

// File: rtl/env_tick_gen.sv
// env_tick_gen: free-running prescaler that emits a one-cycle tick every
// TICK_DIV clock cycles. The first tick falls in cycle TICK_DIV-1 after reset
// release, so its effect lands on the TICK_DIV-th edge.
module env_tick_gen #(
  parameter int unsigned TICK_DIV = 16000
) (
  input  logic CLK,
  input  logic nRST,
  output logic tick
);

  localparam logic [15:0] LAST = 16'(TICK_DIV - 1);

  logic [15:0] cnt;

  // Count 0..TICK_DIV-1 and wrap; only reset restarts the count.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      cnt <= 16'd0;
    end else if (cnt == LAST) begin
      cnt <= 16'd0;
    end else begin
      cnt <= cnt + 16'd1;
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/env_shaper.sv
// env_shaper: ADSR envelope generator plus a two-stage multiply pipeline that
// scales 16-bit offset-binary wavetable samples down to an OUT_W-bit
// offset-binary PWM sample.
// Optional build macro: ENV_EXP_CURVE_EN selects exponential-style DECAY and
// RELEASE decrements; without it every phase is linear.
//
// Sample interface: there is no backpressure. sample_valid is a one-cycle
// strobe qualifying sample_in in that same cycle; exactly two cycles later
// out_valid pulses for one cycle with the matching sample_out. Strobes may
// arrive every cycle. sample_out holds its value between pulses.
module env_shaper #(
  parameter int unsigned TICK_DIV = 16000,
  parameter int unsigned OUT_W    = 10
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             gate,
  input  logic [7:0]       attack_step,
  input  logic [7:0]       decay_step,
  input  logic [7:0]       sustain_lvl,
  input  logic [7:0]       release_step,
  input  logic [15:0]      sample_in,
  input  logic             sample_valid,
  output logic [OUT_W-1:0] sample_out,
  output logic             out_valid,
  output logic [7:0]       env_level,
  output logic [2:0]       env_state,
  output logic             active
);

  import env_pkg::*;

  localparam logic [OUT_W-1:0] MID_OUT = MIDPOINT16[15 -: OUT_W];

  logic       tick;
  logic       gate_q;
  logic       rise;
  logic       fall;
  env_state_t state_q, state_d;
  logic [7:0] env_q, env_d;
  logic [7:0] a_step, d_step, r_step;
  logic [7:0] dec_amt, rel_amt;
  logic [8:0] att_sum;

  env_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .CLK  (CLK),
    .nRST (nRST),
    .tick (tick)
  );

  // Registered gate history; cleared by reset so a gate held high through
  // reset is seen as a fresh note.
  always_ff @(posedge CLK) begin
    if (!nRST) gate_q <= 1'b0;
    else       gate_q <= gate;
  end

  assign rise = gate & ~gate_q;
  assign fall = ~gate & gate_q;

  assign a_step  = eff_step(attack_step);
  assign d_step  = eff_step(decay_step);
  assign r_step  = eff_step(release_step);
  assign att_sum = {1'b0, env_q} + {1'b0, a_step};

`ifdef ENV_EXP_CURVE_EN
  // Decrement proportional to the current level, plus one so it never stalls.
  logic [15:0] dprod, rprod;
  logic        unused_exp;
  assign dprod      = {8'd0, env_q} * {8'd0, d_step};
  assign rprod      = {8'd0, env_q} * {8'd0, r_step};
  assign dec_amt    = dprod[15:8] + 8'd1;
  assign rel_amt    = rprod[15:8] + 8'd1;
  assign unused_exp = ^{dprod[7:0], rprod[7:0]};
`else
  assign dec_amt = d_step;
  assign rel_amt = r_step;
`endif

  // ADSR state and envelope register.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q <= ENV_IDLE;
      env_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      env_q   <= env_d;
    end
  end

  // Next phase and level: gate edges take priority over a coincident tick.
  always_comb begin
    state_d = state_q;
    env_d   = env_q;
    if (rise) begin
      state_d = ENV_ATTACK;
    end else if (fall && (state_q == ENV_ATTACK || state_q == ENV_DECAY ||
                          state_q == ENV_SUSTAIN)) begin
      state_d = ENV_RELEASE;
    end else begin
      case (state_q)
        ENV_IDLE: begin
          env_d = 8'd0;
        end
        ENV_ATTACK: begin
          if (tick) begin
            if (att_sum >= {1'b0, ENV_MAX}) begin
              env_d   = ENV_MAX;
              state_d = ENV_DECAY;
            end else begin
              env_d = att_sum[7:0];
            end
          end
        end
        ENV_DECAY: begin
          if (sustain_lvl == ENV_MAX) begin
            env_d   = sustain_lvl;
            state_d = ENV_SUSTAIN;
          end else if (tick) begin
            if ({1'b0, env_q} <= {1'b0, sustain_lvl} + {1'b0, dec_amt}) begin
              env_d   = sustain_lvl;
              state_d = ENV_SUSTAIN;
            end else begin
              env_d = env_q - dec_amt;
            end
          end
        end
        ENV_SUSTAIN: begin
          env_d = sustain_lvl;
        end
        ENV_RELEASE: begin
          if (tick) begin
            if (env_q <= rel_amt) begin
              env_d   = 8'd0;
              state_d = ENV_IDLE;
            end else begin
              env_d = env_q - rel_amt;
            end
          end
        end
        default: begin
          env_d   = 8'd0;
          state_d = ENV_IDLE;
        end
      endcase
    end
  end

  assign env_level = env_q;
  assign env_state = state_q;
  assign active    = (state_q != ENV_IDLE);

  // Sample pipeline. In IDLE the envelope is 0, so the product is 0 and the
  // output naturally sits at the midpoint.
  logic               v1;
  logic signed [15:0] s_q;
  logic        [7:0]  e_q;
  logic signed [23:0] prod;
  logic        [15:0] out16;

  // Stage 1: capture the signed sample and the envelope in effect this cycle.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      v1  <= 1'b0;
      s_q <= 16'sd0;
      e_q <= 8'd0;
    end else begin
      v1 <= sample_valid;
      if (sample_valid) begin
        s_q <= {~sample_in[15], sample_in[14:0]};
        e_q <= env_q;
      end
    end
  end

  // |s * env| < 2^23, so the product and its >>>8 both fit without overflow.
  assign prod  = s_q * $signed({16'd0, e_q});
  assign out16 = prod[23:8] + MIDPOINT16;

  // Stage 2: publish the rescaled sample and its strobe.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      sample_out <= MID_OUT;
      out_valid  <= 1'b0;
    end else begin
      out_valid <= v1;
      if (v1) sample_out <= out16[15 -: OUT_W];
    end
  end

  generate
    if (OUT_W < 16) begin : g_trim
      logic unused_low;
      assign unused_low = ^out16[15-OUT_W:0];
    end
  endgenerate

endmodule

// File: tb/tb_env_shaper.sv
// tb_env_shaper: randomized bench for env_shaper with a behavioural ADSR
// reference model and an expected-sample queue for the output pipeline.
module tb_env_shaper;

  localparam int TDIV = 4;
  localparam int OW   = 10;

  logic          CLK;
  logic          nRST;
  logic          gate;
  logic [7:0]    attack_step, decay_step, sustain_lvl, release_step;
  logic [15:0]   sample_in;
  logic          sample_valid;
  logic [OW-1:0] sample_out;
  logic          out_valid;
  logic [7:0]    env_level;
  logic [2:0]    env_state;
  logic          active;

  env_shaper #(.TICK_DIV(TDIV), .OUT_W(OW)) dut (
    .CLK          (CLK),
    .nRST         (nRST),
    .gate         (gate),
    .attack_step  (attack_step),
    .decay_step   (decay_step),
    .sustain_lvl  (sustain_lvl),
    .release_step (release_step),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .sample_out   (sample_out),
    .out_valid    (out_valid),
    .env_level    (env_level),
    .env_state    (env_state),
    .active       (active)
  );

  // Clock
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Counters and reference model state
  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  int m_env;     // envelope level 0..255
  int m_ph;      // 0 idle, 1 attack, 2 decay, 3 sustain, 4 release
  int m_cnt;     // clock cycles since reset, modulo TDIV
  int m_gprev;   // gate as seen last cycle
  logic [OW-1:0] m_out;
  logic [OW-1:0] exp_q[$];
  int            due_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, obs, exp_v);
    end
  endtask

  function automatic int dec_of(input int env, input int step);
    int st;
    st = (step == 0) ? 1 : step;
`ifdef ENV_EXP_CURVE_EN
    return ((env * st) / 256) + 1;
`else
    return st;
`endif
  endfunction

  // Offset-binary in, scale by env/256 (floor), offset-binary out.
  function automatic logic [OW-1:0] shape(input logic [15:0] x, input int env);
    int s, p, y, u;
    s = int'(x) - 32768;
    p = s * env;
    y = p >>> 8;
    u = y + 32768;
    return OW'(u >> (16 - OW));
  endfunction

  // Predict the effect of the next rising edge from the inputs now applied.
  task automatic model_advance();
    bit tick, rise, fall;
    int st, e;
    if (!nRST) begin
      m_env = 0; m_ph = 0; m_cnt = 0; m_gprev = 0;
      m_out = OW'(10'h200);
      exp_q.delete();
      due_q.delete();
      return;
    end
    if (sample_valid) begin
      exp_q.push_back(shape(sample_in, m_env));
      due_q.push_back(cyc + 2);
    end
    tick    = (m_cnt == TDIV - 1);
    m_cnt   = (m_cnt + 1) % TDIV;
    rise    = gate && (m_gprev == 0);
    fall    = !gate && (m_gprev == 1);
    m_gprev = gate ? 1 : 0;
    if (rise) begin
      m_ph = 1;
    end else if (fall && m_ph >= 1 && m_ph <= 3) begin
      m_ph = 4;
    end else begin
      case (m_ph)
        0: m_env = 0;
        1: if (tick) begin
             st = (attack_step == 0) ? 1 : int'(attack_step);
             m_env = (m_env + st > 255) ? 255 : m_env + st;
             if (m_env == 255) m_ph = 2;
           end
        2: if (sustain_lvl == 8'd255) begin
             m_env = 255; m_ph = 3;
           end else if (tick) begin
             e = m_env - dec_of(m_env, int'(decay_step));
             if (e <= int'(sustain_lvl)) begin
               m_env = int'(sustain_lvl); m_ph = 3;
             end else begin
               m_env = e;
             end
           end
        3: m_env = int'(sustain_lvl);
        4: if (tick) begin
             e = m_env - dec_of(m_env, int'(release_step));
             m_env = (e < 0) ? 0 : e;
             if (m_env == 0) m_ph = 0;
           end
        default: m_ph = 0;
      endcase
    end
  endtask

  task automatic check_outputs();
    bit exp_ov;
    exp_ov = (due_q.size() > 0) && (due_q[0] == cyc);
    if (exp_ov) begin
      m_out = exp_q.pop_front();
      void'(due_q.pop_front());
    end
    check("out_valid", 32'(out_valid), 32'(exp_ov));
    check("sample_out", 32'(sample_out), 32'(m_out));
    check("env_level", 32'(env_level), 32'(m_env));
    check("env_state", 32'(env_state), 32'(m_ph));
    check("active", 32'(active), 32'(m_ph != 0));
  endtask

  // Inputs are set after a falling edge; outputs are checked on the next one.
  task automatic run_cycle();
    model_advance();
    @(posedge CLK);
    cyc++;
    @(negedge CLK);
    check_outputs();
  endtask

  task automatic rnd_sample();
    sample_valid = ($urandom_range(0, 1) == 1);
    sample_in    = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
  endtask

  initial begin
    nRST = 1'b0; gate = 1'b0;
    attack_step = 8'd64; decay_step = 8'd100; sustain_lvl = 8'd80; release_step = 8'd0;
    sample_valid = 1'b1; sample_in = 16'hFFFF;

    // Reset held while full-scale samples strobe in.
    repeat (5) run_cycle();

    // Attack then decay into sustain.
    nRST = 1'b1; gate = 1'b1;
    repeat (30) begin rnd_sample(); run_cycle(); end
    check("attack_decay_state", 32'(env_state), 32'd3);
    check("attack_decay_level", 32'(env_level), 32'd80);

    // Live sustain change.
    sustain_lvl = 8'd40;
    run_cycle();
    check("sustain_follow", 32'(env_level), 32'd40);
    sustain_lvl = 8'd80;
    repeat (2) run_cycle();

    // Release at step 0 (treated as 1): 80 ticks to silence.
    gate = 1'b0;
    repeat (330) begin rnd_sample(); run_cycle(); end
    check("release_idle_state", 32'(env_state), 32'd0);
    check("release_idle_active", 32'(active), 32'd0);

    // Retrigger during release at level 50.
    gate = 1'b1;
    repeat (30) begin rnd_sample(); run_cycle(); end
    gate = 1'b0;
    for (int i = 0; i < 400 && m_env != 50; i++) begin rnd_sample(); run_cycle(); end
    check("release_reach50", 32'(env_level), 32'd50);
    gate = 1'b1;
    run_cycle();
    check("retrig_level", 32'(env_level), 32'd50);
    check("retrig_state", 32'(env_state), 32'd1);
    repeat (TDIV) run_cycle();
    check("retrig_step", 32'(env_level), 32'd114);

    // One-cycle reset mid-attack with samples in flight.
    sample_valid = 1'b1; sample_in = 16'hFFFF;
    run_cycle();
    nRST = 1'b0;
    run_cycle();
    check("rst_env", 32'(env_level), 32'd0);
    check("rst_state", 32'(env_state), 32'd0);
    check("rst_out", 32'(sample_out), 32'h200);
    check("rst_valid", 32'(out_valid), 32'd0);
    nRST = 1'b1; sample_valid = 1'b0;
    run_cycle();

    // Randomized soak: gate toggles, parameter changes, occasional reset.
    for (int i = 0; i < 2500; i++) begin
      rnd_sample();
      if ($urandom_range(0, 39) == 0) gate = ~gate;
      if ($urandom_range(0, 59) == 0) begin
        attack_step  = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
        decay_step   = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
        release_step = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
        sustain_lvl  = ($urandom_range(0, 7) == 0) ? 8'd255 : 8'($urandom_range(0, 254));
      end
      if ($urandom_range(0, 99) == 0) sustain_lvl = 8'($urandom_range(0, 255));
      nRST = ($urandom_range(0, 499) != 0);
      run_cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
